// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Purpose:
//   This block buffers the bytes that the CPU stores to the UART MMIO address.
//   It passes them to the uart transmitter one byte at a time. Consecutive
//   write strobes are spaced GAP_CYCLES clocks apart. The transmitter has no
//   busy output, so this fixed spacing is the only thing that stops a byte
//   from overwriting the frame that is still being shifted out.
//
// Parameters:
//   DEPTH       FIFO entries (power of 2, >= 2)
//   GAP_CYCLES  clocks from one uart_wr pulse to the next (>= 2)
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   wr_en     in   CPU store to the UART address, one pulse per byte
//   wr_data   in   byte to transmit
//   full      out  FIFO holds DEPTH entries
//   empty     out  FIFO holds no entries
//   level     out  current entry count
//   overflow  out  sticky flag: a write arrived while full (cleared by rst)
//   busy      out  a frame gap is running, or bytes are still queued
//   uart_wr   out  one-cycle write strobe to the uart module
//   uart_dat  out  byte for the uart module, valid while uart_wr=1
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 8680
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       busy,
    output logic                       uart_wr,
    output logic [7:0]                 uart_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(GAP_CYCLES);

    // Each launch loads GAP_CYCLES-1. The next launch happens on the edge
    // where the counter already reads zero, so pulses are GAP_CYCLES apart.
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    // The pointers are one bit wider than the index. The extra MSB tells a
    // full FIFO apart from an empty one when the index bits are equal.
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           uart_wr_q, uart_wr_d;
    logic [7:0]     uart_dat_q, uart_dat_d;
    logic           overflow_q, overflow_d;
    logic [7:0]     mem_q [DEPTH];

    logic           push;
    logic           pop;
    logic [7:0]     head;

    // The status outputs are derived only from the registered pointers.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign overflow = overflow_q;
    assign uart_wr  = uart_wr_q;
    assign uart_dat = uart_dat_q;
    assign busy     = (state_q != ST_IDLE) || !empty;

    // A write is accepted only when the FIFO is not full. A pop in the same
    // cycle does not make room for that write, because full comes from the
    // registered pointers.
    assign push = wr_en && !full;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        uart_wr_d  = 1'b0;
        uart_dat_d = uart_dat_q;
        overflow_d = overflow_q || (wr_en && full);
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    uart_wr_d  = 1'b1;
                    uart_dat_d = head;
                    cnt_d      = GAP_LOAD;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (!empty) begin
                        // Launch the next byte on this edge and stay in WAIT
                        // for the next gap.
                        pop        = 1'b1;
                        uart_wr_d  = 1'b1;
                        uart_dat_d = head;
                        cnt_d      = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_ptr_d = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + 1'b1) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            uart_wr_q  <= 1'b0;
            uart_dat_q <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            uart_wr_q  <= uart_wr_d;
            uart_dat_q <= uart_dat_d;
            overflow_q <= overflow_d;
        end
    end

    // The storage array has no reset. Its contents are meaningless until the
    // pointers have moved past an entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed bench for uart_tx_scheduler with DEPTH=4 and GAP_CYCLES=20.
// Inputs are driven 1 time unit after each rising edge and sampled at the
// next rising edge. Outputs are read 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int DEPTH = 4;
    localparam int GAP   = 20;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       overflow;
    logic       busy;
    logic       uart_wr;
    logic [7:0] uart_dat;

    int checks;
    int failures;

    uart_tx_scheduler #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .busy     (busy),
        .uart_wr  (uart_wr),
        .uart_dat (uart_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge. Outputs are then readable and inputs may be
    // changed for the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Tick until a uart_wr pulse is seen, or until max edges have passed.
    task automatic wait_pulse(input int max, output int n, output logic [7:0] d, output bit ok);
        n  = 0;
        ok = 1'b0;
        d  = 8'h00;
        while (n < max && !ok) begin
            tick();
            n++;
            if (uart_wr === 1'b1) begin
                ok = 1'b1;
                d  = uart_dat;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s drain timeout: busy=%b required 0", name, busy);
        end
    endtask

    // Check the outputs right after reset.
    task automatic test_reset();
        do_reset();
        checks++;
        if ({full, empty, level, overflow, busy, uart_wr, uart_dat} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("[TB] FAIL reset_state: full=%b empty=%b level=%0d ovf=%b busy=%b wr=%b dat=%h required 0 1 0 0 0 0 00",
                     full, empty, level, overflow, busy, uart_wr, uart_dat);
        end
    endtask

    // Send one byte. uart_wr is high one edge after the write. busy falls
    // GAP edges after the launch.
    task automatic test_single();
        do_reset();
        wr_en = 1'b1; wr_data = 8'h41;
        tick();
        wr_en = 1'b0;
        checks++;
        if (level !== 3'd1 || uart_wr !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_accept: level=%0d wr=%b busy=%b required 1 0 1", level, uart_wr, busy);
        end
        tick();
        checks++;
        if (uart_wr !== 1'b1 || uart_dat !== 8'h41 || level !== 3'd0) begin
            failures++;
            $display("[TB] FAIL single_launch: wr=%b dat=%h level=%0d required 1 41 0", uart_wr, uart_dat, level);
        end
        tick();
        checks++;
        if (uart_wr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_width: wr=%b required 0", uart_wr);
        end
        repeat (GAP - 2) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_busy_gap: busy=%b required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || uart_dat !== 8'h41) begin
            failures++;
            $display("[TB] FAIL single_idle: busy=%b dat=%h required 0 41", busy, uart_dat);
        end
    endtask

    // Write three bytes on consecutive edges. The pulses must be GAP edges
    // apart and keep the write order. The level must peak at 2.
    task automatic test_back_to_back();
        logic [7:0] exp [3];
        int         n;
        logic [7:0] d;
        bit         ok;
        exp[0] = 8'h48; exp[1] = 8'h69; exp[2] = 8'h0A;
        do_reset();
        wr_en = 1'b1; wr_data = exp[0];
        tick();
        wr_data = exp[1];
        tick();
        checks++;
        if (uart_wr !== 1'b1 || uart_dat !== 8'h48) begin
            failures++;
            $display("[TB] FAIL burst_first: wr=%b dat=%h required 1 48", uart_wr, uart_dat);
        end
        wr_data = exp[2];
        tick();
        wr_en = 1'b0;
        checks++;
        if (level !== 3'd2) begin
            failures++;
            $display("[TB] FAIL burst_level_peak: level=%0d required 2", level);
        end
        // The write of the third byte is one edge after the first launch, so
        // the second pulse is GAP-1 edges later.
        wait_pulse(GAP + 5, n, d, ok);
        checks++;
        if (!ok || n != GAP - 1 || d !== exp[1]) begin
            failures++;
            $display("[TB] FAIL burst_second: seen=%b edges=%0d dat=%h required 1 %0d 69", ok, n, d, GAP - 1);
        end
        wait_pulse(GAP + 5, n, d, ok);
        checks++;
        if (!ok || n != GAP || d !== exp[2]) begin
            failures++;
            $display("[TB] FAIL burst_third: seen=%b edges=%0d dat=%h required 1 %0d 0a", ok, n, d, GAP);
        end
        wait_idle("burst");
    endtask

    // Write six bytes in a row. Byte 1 launches, bytes 2 to 5 fill the FIFO,
    // byte 6 is dropped and sets the sticky overflow flag.
    task automatic test_overflow();
        int         n;
        logic [7:0] d;
        bit         ok;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        checks++;
        if (full !== 1'b1 || level !== 3'd4 || overflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_full: full=%b level=%0d ovf=%b required 1 4 1", full, level, overflow);
        end
        for (int i = 2; i <= 5; i++) begin
            wait_pulse(GAP + 5, n, d, ok);
            checks++;
            if (!ok || d !== 8'(i)) begin
                failures++;
                $display("[TB] FAIL ovf_drain_%0d: seen=%b dat=%h required 1 %h", i, ok, d, 8'(i));
            end
        end
        // No sixth byte may appear.
        wait_pulse(GAP + 5, n, d, ok);
        checks++;
        if (ok) begin
            failures++;
            $display("[TB] FAIL ovf_dropped: extra pulse dat=%h required none", d);
        end
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_sticky: ovf=%b busy=%b required 1 0", overflow, busy);
        end
        do_reset();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_clear: ovf=%b required 0", overflow);
        end
    endtask

    // A byte written during the gap must wait for the counter-zero edge.
    task automatic test_late_arrival();
        int         n;
        logic [7:0] d;
        bit         ok;
        do_reset();
        wr_en = 1'b1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        tick();
        checks++;
        if (uart_wr !== 1'b1 || uart_dat !== 8'h55) begin
            failures++;
            $display("[TB] FAIL late_first: wr=%b dat=%h required 1 55", uart_wr, uart_dat);
        end
        repeat (13) tick();
        wr_en = 1'b1; wr_data = 8'h66;
        tick();
        wr_en = 1'b0;
        checks++;
        if (uart_wr !== 1'b0 || level !== 3'd1) begin
            failures++;
            $display("[TB] FAIL late_queued: wr=%b level=%0d required 0 1", uart_wr, level);
        end
        // Launch at edge 1 and write at edge 15, so the pulse is at edge 21.
        wait_pulse(GAP + 5, n, d, ok);
        checks++;
        if (!ok || n != 6 || d !== 8'h66) begin
            failures++;
            $display("[TB] FAIL late_launch: seen=%b edges=%0d dat=%h required 1 6 66", ok, n, d);
        end
        wait_idle("late");
    endtask

    // Send ten bytes one at a time. The pointers wrap twice around DEPTH=4.
    task automatic test_pointer_wrap();
        int         n;
        logic [7:0] d;
        bit         ok;
        int         bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
            tick();
            wr_en = 1'b0;
            if (level > 3'd1) bad++;
            wait_pulse(GAP + 5, n, d, ok);
            checks++;
            if (!ok || d !== (8'hA0 + 8'(i))) begin
                failures++;
                $display("[TB] FAIL wrap_byte_%0d: seen=%b dat=%h required 1 %h", i, ok, d, 8'hA0 + 8'(i));
            end
        end
        checks++;
        if (bad != 0 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wrap_level: over_level=%0d ovf=%b required 0 0", bad, overflow);
        end
        wait_idle("wrap");
    endtask

    // A reset in the middle of a gap drops the queue. The next byte then
    // launches with the normal one-edge latency.
    task automatic test_reset_mid();
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'hC0 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (uart_wr !== 1'b0 || level !== 3'd0 || busy !== 1'b0 || empty !== 1'b1 || uart_dat !== 8'h00) begin
            failures++;
            $display("[TB] FAIL rst_mid: wr=%b level=%0d busy=%b empty=%b dat=%h required 0 0 0 1 00",
                     uart_wr, level, busy, empty, uart_dat);
        end
        wr_en = 1'b1; wr_data = 8'h7E;
        tick();
        wr_en = 1'b0;
        tick();
        checks++;
        if (uart_wr !== 1'b1 || uart_dat !== 8'h7E) begin
            failures++;
            $display("[TB] FAIL rst_relaunch: wr=%b dat=%h required 1 7e", uart_wr, uart_dat);
        end
        wait_idle("rst_mid");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_late_arrival();
        test_pointer_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Buffers bytes stored by the CPU to the UART MMIO address.
- Sequences their hand-off to the uart transmitter one byte at a time, spaced by a fixed frame time. The transmitter has no busy output, so this spacing is what prevents overrun.
- Sits between the Memory Access stage's UART store decode and the uart module's write strobe and data inputs.
- Exposes full/level status so the CPU stage sequencer can stall stores instead of dropping them.

Parameters:
- DEPTH, 16, FIFO entries. Power of 2, minimum 2.
- GAP_CYCLES, 8680, clock cycles from one uart_wr pulse to the next. 8680 = 10 bits x 868 clocks per bit (100 MHz, 115200 baud). Minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  CPU store to UART address; one pulse per byte
- wr_data  in  8  byte to transmit (store data [7:0])
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- level  out  $clog2(DEPTH)+1  current entry count
- overflow  out  1  sticky: a write arrived while full
- busy  out  1  state != IDLE, or FIFO not empty
- uart_wr  out  1  one-cycle write strobe to the uart module
- uart_dat  out  8  byte to the uart module; valid while uart_wr=1

Behaviour:
- Reset (rst sampled high at a clk edge):
  - Pointers cleared; level=0, empty=1, full=0, overflow=0, busy=0.
  - uart_wr=0, uart_dat=0, state=IDLE, gap counter=0.
  - Reset mid-frame discards queued bytes and any remaining gap; the next byte may launch immediately after reset.
- FIFO:
  - Circular buffer with read/write pointers 1 bit wider than the index (wrap via MSB compare).
  - full/empty/level are derived from registered pointers only.
- Write:
  - wr_en=1 with full=0: wr_data is stored at an edge; level increments at that edge.
  - wr_en=1 with full=1: byte dropped and overflow set. Applies even if a pop happens the same cycle.
  - overflow is cleared only by rst.
- Pop + write in the same cycle (not full): both take effect; level unchanged.
- FSM states IDLE, WAIT:
  - IDLE, empty=0 at an edge:
    - Pop the head entry.
    - Register uart_wr=1 and uart_dat=head for exactly one cycle.
    - Load the counter with GAP_CYCLES-1; go to WAIT.
  - IDLE, empty=1: uart_wr=0, uart_dat holds its last value.
  - WAIT: counter decrements each cycle; uart_wr=0.
    - Counter reaches 0 and empty=0: pop and launch the next byte at the same edge; stay in WAIT with the counter reloaded.
    - Counter reaches 0 and empty=1: go to IDLE.
- Timing:
  - Latency: wr_en sampled at edge N into an empty, idle block gives uart_wr=1 between edges N+1 and N+2.
  - Back-to-back queued bytes produce uart_wr pulses exactly GAP_CYCLES cycles apart, rising edge to rising edge.
  - A byte written during WAIT into an empty FIFO launches at the counter-zero edge. If it arrives after IDLE was entered, it follows the latency rule.
- Ordering: bytes leave in FIFO order; no reordering or duplication.
- busy deasserts only when state=IDLE and empty=1. The CPU uses this to drain before halt.
- Stall contract: the CPU stage sequencer holds its MA stage while (UART store && full). wr_en must therefore not be asserted while full in normal operation; overflow flags a contract violation.

Test Plan:
- Single byte, DEPTH=4, GAP_CYCLES=20: write 0x41 at edge 10 -> uart_wr high edges 11-12 with uart_dat=0x41; busy low from edge 31 (IDLE, empty).
- Burst: write 0x48,0x69,0x0A on consecutive edges 5,6,7 -> uart_wr pulses at edges 6, 26, 46 with data 0x48, 0x69, 0x0A in order; level peaks at 2.
- Fill/overflow, DEPTH=4: write 6 bytes 0x01-0x06 on consecutive edges while the first frame is in flight -> first byte launched; 0x02-0x05 queued (full=1); 0x06 dropped; overflow=1 and stays 1 until rst.
- Late arrival: write 0x55 at edge 0, then 0x66 during WAIT at edge 15 -> 0x66 launches at edge 21 (counter zero), not earlier.
- Pointer wrap, DEPTH=4: stream 10 bytes, each written after the previous launches -> all 10 emitted in order; level never exceeds 1; no overflow.
- Reset mid-operation: 3 bytes queued, rst at edge 8 of the first gap -> uart_wr=0, level=0, busy=0 next cycle; a new write 0x7E launches with the normal 1-edge latency.
